// File: rtl/hack_prog_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the Hack program loader.
// The master side is the loader. The slave side is the environment: the UART
// receiver, the instruction RAM and the CPU reset input.
interface hack_prog_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load_en;
    logic [14:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_we;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  rx_data, rx_valid, load_en,
        output imem_addr, imem_data, imem_we, cpu_reset, busy, done, error
    );

    modport slave (
        output rx_data, rx_valid, load_en,
        input  imem_addr, imem_data, imem_we, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/hack_prog_loader.sv
// Serial program loader for the Hack CPU.
// The loader receives the frame SYNC, LEN_HI, LEN_LO, LEN big-endian words, CHK.
// It writes the words into instruction RAM starting at address 0.
// The CPU is held in reset until the 8-bit frame checksum verifies.
module hack_prog_loader #(
    parameter int unsigned MAX_WORDS = 32768,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter bit          BOOT_RUN  = 1'b0,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input logic               CLK,
    input logic               reset_n,
    hack_prog_loader_if.master bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR
    } state_t;

    state_t        state, state_next;
    logic [15:0]   len;
    logic [15:0]   len_full;
    logic [7:0]    hi;
    logic [7:0]    sum;
    logic [7:0]    sum_next;
    logic [14:0]   count;
    logic [TW-1:0] tmo;
    logic          in_frame;
    logic          sync_hit;
    logic          wr_fire;
    logic          last_word;
    logic          pass;
    logic          fail;

    // State register; the power-up state depends on whether a preloaded image should run.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= BOOT_RUN ? RUN : IDLE;
        else          state <= state_next;
    end

    // Next-state decode plus the event strobes that drive the datapath.
    always_comb begin
        state_next = state;
        sync_hit   = 1'b0;
        wr_fire    = 1'b0;
        pass       = 1'b0;
        fail       = 1'b0;
        len_full   = {len[15:8], bus.rx_data};
        sum_next   = sum + bus.rx_data;
        last_word  = (({1'b0, count} + 16'd1) == len);
        in_frame   = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CHECK);
        case (state)
            IDLE, RUN, ERROR: begin
                if (bus.rx_valid && bus.load_en && (bus.rx_data == SYNC)) begin
                    sync_hit   = 1'b1;
                    state_next = LEN_HI;
                end
            end
            LEN_HI:  if (bus.rx_valid) state_next = LEN_LO;
            LEN_LO: begin
                if (bus.rx_valid) begin
                    if (len_full[15] || (32'(len_full) > MAX_WORDS)) fail = 1'b1;
                    else if (len_full == 16'd0)                       state_next = CHECK;
                    else                                              state_next = DATA_HI;
                end
            end
            DATA_HI: if (bus.rx_valid) state_next = DATA_LO;
            DATA_LO: begin
                if (bus.rx_valid) begin
                    wr_fire    = 1'b1;
                    state_next = last_word ? CHECK : DATA_HI;
                end
            end
            CHECK: begin
                if (bus.rx_valid) begin
                    if (sum_next == 8'h00) begin
                        pass       = 1'b1;
                        state_next = RUN;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A received byte always reloads the idle counter, so a timeout fires only on a quiet cycle.
        if (in_frame && !bus.rx_valid && (tmo == TW'(TIMEOUT - 1))) fail = 1'b1;
        if (fail) state_next = ERROR;
    end

    // Datapath and registered outputs. cpu_reset and busy follow the next state.
    // As a result they change together with the state and never glitch inside a frame.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            len           <= '0;
            hi            <= '0;
            sum           <= '0;
            count         <= '0;
            tmo           <= '0;
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_data <= '0;
            bus.cpu_reset <= !BOOT_RUN;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            bus.imem_we   <= wr_fire;
            bus.cpu_reset <= (state_next != RUN);
            bus.busy      <= (state_next == LEN_HI) || (state_next == LEN_LO) ||
                             (state_next == DATA_HI) || (state_next == DATA_LO) ||
                             (state_next == CHECK);
            if (sync_hit) begin
                sum       <= '0;
                count     <= '0;
                tmo       <= '0;
                bus.done  <= 1'b0;
                bus.error <= 1'b0;
            end else if (in_frame) begin
                if (bus.rx_valid) begin
                    sum <= sum_next;
                    tmo <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end
            if (bus.rx_valid && (state == LEN_HI))  len[15:8] <= bus.rx_data;
            if (bus.rx_valid && (state == LEN_LO))  len[7:0]  <= bus.rx_data;
            if (bus.rx_valid && (state == DATA_HI)) hi        <= bus.rx_data;
            // The address holds at len-1 after the final word instead of stepping past it.
            if (wr_fire) begin
                bus.imem_addr <= count;
                bus.imem_data <= {hi, bus.rx_data};
                if (!last_word) count <= count + 1'b1;
            end
            if (pass) bus.done  <= 1'b1;
            if (fail) bus.error <= 1'b1;
        end
    end

endmodule
